// File: rtl/switch_pkg.sv
`default_nettype none
// ============================================================================
// switch_pkg : shared stream word type and transmitter state encoding
// Revision   : 1.0
// ============================================================================
package switch_pkg;

  typedef logic [8:0] stream_word_t;

  localparam int STREAM_LAST_BIT = 8;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_GAP  = 2'd2
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : single-clock FIFO, registered read data with 1-cycle latency
// Revision  : 1.0
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2048
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             write_enable_i,
  input  logic [WIDTH-1:0] write_data_i,
  input  logic             read_enable_i,
  output logic [WIDTH-1:0] read_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_wr;
  logic             do_rd;

  // Flags come from the registered count, so a read while full frees its slot next cycle.
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_wr   = write_enable_i && !full_o;
  assign do_rd   = read_enable_i && !empty_o;

  always_ff @(posedge clock) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= write_data_i;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      read_data_o <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_rd) begin
        rd_ptr_q    <= rd_ptr_q + AW'(1);
        read_data_o <= mem_q[rd_ptr_q];
      end
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/module_frame_transmitter.sv
`default_nettype none
// ============================================================================
// module_frame_transmitter : buffers user frames, streams complete frames to switch
// Revision                 : 1.0
// ============================================================================
module module_frame_transmitter
  import switch_pkg::*;
#(
  parameter int BUFFER_DEPTH    = 2048,
  parameter int MAX_FRAMES      = 16,
  parameter int INTER_FRAME_GAP = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [7:0]                      write_data,
  input  logic                            write_last,
  input  logic                            write_enable,
  output logic                            write_ready,
  input  logic                            clear_error,
  input  logic                            module_transmit_data_ready,
  output logic [8:0]                      module_transmit_data,
  output logic                            module_transmit_data_enable,
  output logic [$clog2(MAX_FRAMES+1)-1:0] frames_pending,
  output logic                            overflow_error,
  output logic                            busy
);

  localparam int FPW = $clog2(MAX_FRAMES + 1);
  localparam int GW  = (INTER_FRAME_GAP > 1) ? $clog2(INTER_FRAME_GAP + 1) : 1;

  tx_state_t    state_q;
  logic         enable_q;
  logic [GW-1:0] gap_q;
  logic [FPW-1:0] pending_q;
  logic         frame_open_q;
  logic         overflow_q;

  stream_word_t fifo_rdata;
  logic         fifo_full;
  logic         fifo_empty;
  logic         wr_accept;
  logic         tx_fire;
  logic         tx_last;
  logic         have_frame;
  logic         gap_done;
  logic         start_frame;
  logic         rd_en;

  assign write_ready = !fifo_full && ((pending_q < FPW'(MAX_FRAMES)) || frame_open_q);
  assign wr_accept   = write_enable && write_ready;
  assign tx_fire     = enable_q && module_transmit_data_ready;
  assign tx_last     = tx_fire && fifo_rdata[STREAM_LAST_BIT];
  assign have_frame  = (pending_q != '0);
  assign gap_done    = (state_q == TX_GAP) && (gap_q == GW'(1));
  // The last gap cycle doubles as the idle decision so the gap is exactly INTER_FRAME_GAP.
  assign start_frame = have_frame && ((state_q == TX_IDLE) || gap_done);
  assign rd_en       = !fifo_empty && (start_frame || (tx_fire && !fifo_rdata[STREAM_LAST_BIT]));

  sync_fifo #(
    .WIDTH (9),
    .DEPTH (BUFFER_DEPTH)
  ) u_fifo (
    .clock          (clock),
    .reset          (reset),
    .write_enable_i (wr_accept),
    .write_data_i   ({write_last, write_data}),
    .read_enable_i  (rd_en),
    .read_data_o    (fifo_rdata),
    .full_o         (fifo_full),
    .empty_o        (fifo_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= TX_IDLE;
      enable_q <= 1'b0;
      gap_q    <= '0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (start_frame) begin
            state_q  <= TX_SEND;
            enable_q <= 1'b1;
          end
        end
        TX_SEND: begin
          if (tx_last) begin
            enable_q <= 1'b0;
            gap_q    <= GW'(INTER_FRAME_GAP);
            state_q  <= (INTER_FRAME_GAP == 0) ? TX_IDLE : TX_GAP;
          end
        end
        TX_GAP: begin
          if (gap_done) begin
            state_q  <= start_frame ? TX_SEND : TX_IDLE;
            enable_q <= start_frame;
          end else begin
            gap_q <= gap_q - GW'(1);
          end
        end
        default: begin
          state_q  <= TX_IDLE;
          enable_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q    <= '0;
      frame_open_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      case ({wr_accept && write_last, tx_last})
        2'b10:   pending_q <= pending_q + FPW'(1);
        2'b01:   pending_q <= pending_q - FPW'(1);
        default: pending_q <= pending_q;
      endcase
      if (wr_accept) begin
        frame_open_q <= !write_last;
      end
      if (write_enable && !write_ready) begin
        overflow_q <= 1'b1;
      end else if (clear_error) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign module_transmit_data        = fifo_rdata;
  assign module_transmit_data_enable = enable_q;
  assign frames_pending              = pending_q;
  assign overflow_error              = overflow_q;
  assign busy                        = (state_q != TX_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_module_frame_transmitter.sv
`default_nettype none
// ============================================================================
// tb_module_frame_transmitter : scoreboard bench for module_frame_transmitter
// Revision                    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_module_frame_transmitter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] write_data = '0;
  logic       write_last = 1'b0;
  logic       write_enable = 1'b0;
  logic       write_ready;
  logic       clear_error = 1'b0;
  logic       module_transmit_data_ready = 1'b0;
  logic [8:0] module_transmit_data;
  logic       module_transmit_data_enable;
  logic [4:0] frames_pending;
  logic       overflow_error;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  logic [8:0] sb [$];

  bit         hold_chk = 0;
  bit         in_frame = 0;
  bit         after_last = 0;
  logic [8:0] held = '0;
  logic [8:0] exp_w;
  int         idle_cnt = 0;
  int         last_gap = -1;
  int         frames_sent = 0;
  int         words_in_frame = 0;

  module_frame_transmitter dut (
    .clock                       (clock),
    .reset                       (reset),
    .write_data                  (write_data),
    .write_last                  (write_last),
    .write_enable                (write_enable),
    .write_ready                 (write_ready),
    .clear_error                 (clear_error),
    .module_transmit_data_ready  (module_transmit_data_ready),
    .module_transmit_data        (module_transmit_data),
    .module_transmit_data_enable (module_transmit_data_enable),
    .frames_pending              (frames_pending),
    .overflow_error              (overflow_error),
    .busy                        (busy)
  );

  always #5 clock = ~clock;

  // Output monitor: words seen with enable && ready here transfer on the next rising edge.
  always @(negedge clock) begin
    if (reset) begin
      hold_chk       = 0;
      in_frame       = 0;
      after_last     = 0;
      idle_cnt       = 0;
      words_in_frame = 0;
    end else begin
      if (hold_chk) begin
        n_vec++;
        if (module_transmit_data_enable !== 1'b1 || module_transmit_data !== held) begin
          n_err++;
          $display("FAIL hold: got en=%b data=%h, need en=1 data=%h",
                   module_transmit_data_enable, module_transmit_data, held);
        end
      end
      if (in_frame) begin
        n_vec++;
        if (module_transmit_data_enable !== 1'b1) begin
          n_err++;
          $display("FAIL enable_mid_frame: got en=%b, need 1", module_transmit_data_enable);
        end
      end
      if (after_last) begin
        if (module_transmit_data_enable !== 1'b1) idle_cnt++;
        else begin
          last_gap   = idle_cnt;
          after_last = 0;
        end
      end
      hold_chk = module_transmit_data_enable && !module_transmit_data_ready;
      held     = module_transmit_data;
      if (module_transmit_data_enable && module_transmit_data_ready) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_word: got %h, need none", module_transmit_data);
        end else begin
          exp_w = sb.pop_front();
          if (module_transmit_data !== exp_w) begin
            n_err++;
            $display("FAIL word: got %h, need %h", module_transmit_data, exp_w);
          end
        end
        words_in_frame++;
        if (module_transmit_data[8]) begin
          in_frame       = 0;
          after_last     = 1;
          idle_cnt       = 0;
          words_in_frame = 0;
          frames_sent++;
        end else begin
          in_frame = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic last);
    int t = 0;
    while (write_ready !== 1'b1 && t < 5000) begin
      tick();
      t++;
    end
    if (t >= 5000) begin
      n_err++;
      $display("FAIL write_ready_timeout: got 0, need 1");
    end
    write_data   = d;
    write_last   = last;
    write_enable = 1'b1;
    sb.push_back({last, d});
    tick();
    write_enable = 1'b0;
    write_last   = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(busy === 1'b0 && frames_pending === 5'd0 && module_transmit_data_enable === 1'b0)
           && t < 5000) begin
      tick();
      t++;
    end
    if (t >= 5000) begin
      n_err++;
      $display("FAIL idle_timeout: got busy=%b pend=%0d, need 0/0", busy, frames_pending);
    end
  endtask

  task automatic wait_enable();
    int t = 0;
    while (module_transmit_data_enable !== 1'b1 && t < 5000) begin
      tick();
      t++;
    end
    if (t >= 5000) begin
      n_err++;
      $display("FAIL enable_timeout: got 0, need 1");
    end
  endtask

  task automatic wait_frames(input int target);
    int t = 0;
    while (frames_sent < target && t < 5000) begin
      tick();
      t++;
    end
    if (t >= 5000) begin
      n_err++;
      $display("FAIL frames_timeout: got %0d, need %0d", frames_sent, target);
    end
  endtask

  task automatic test_reset();
    #12;
    n_vec++;
    if ({module_transmit_data, module_transmit_data_enable, frames_pending, overflow_error, busy} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got data=%h en=%b pend=%0d ovf=%b busy=%b, need all 0",
               module_transmit_data, module_transmit_data_enable, frames_pending, overflow_error, busy);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_frame();
    module_transmit_data_ready = 1'b1;
    push_byte(8'hA1, 1'b0);
    push_byte(8'hB2, 1'b0);
    push_byte(8'hC3, 1'b1);
    n_vec++;
    if (frames_pending !== 5'd1 || module_transmit_data_enable !== 1'b0) begin
      n_err++;
      $display("FAIL t1_pending: got pend=%0d en=%b, need 1/0", frames_pending, module_transmit_data_enable);
    end
    tick();
    n_vec++;
    if (module_transmit_data_enable !== 1'b1 || module_transmit_data !== 9'h0A1) begin
      n_err++;
      $display("FAIL t1_latency: got en=%b data=%h, need 1/0a1", module_transmit_data_enable, module_transmit_data);
    end
    repeat (3) tick();
    n_vec++;
    if (frames_pending !== 5'd0 || busy !== 1'b1 || module_transmit_data_enable !== 1'b0) begin
      n_err++;
      $display("FAIL t1_after_last: got pend=%0d busy=%b en=%b, need 0/1/0",
               frames_pending, busy, module_transmit_data_enable);
    end
    repeat (3) tick();
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL t1_gap_end: got busy=%b, need 1", busy);
    end
    tick();
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL t1_idle: got busy=%b, need 0", busy);
    end
  endtask

  task automatic test_ready_toggle();
    logic [4:0] pat;
    pat = 5'b11001;
    module_transmit_data_ready = 1'b0;
    push_byte(8'hA1, 1'b0);
    push_byte(8'hB2, 1'b0);
    push_byte(8'hC3, 1'b1);
    wait_enable();
    for (int i = 4; i >= 0; i--) begin
      module_transmit_data_ready = pat[i];
      tick();
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL t2_drained: got %0d left, need 0", sb.size());
    end
    module_transmit_data_ready = 1'b1;
    wait_idle();
  endtask

  task automatic test_two_frames();
    int base;
    module_transmit_data_ready = 1'b0;
    for (int i = 0; i < 60; i++) push_byte(8'(i), i == 59);
    for (int i = 0; i < 60; i++) push_byte(8'(i + 100), i == 59);
    n_vec++;
    if (frames_pending !== 5'd2) begin
      n_err++;
      $display("FAIL t3_pend2: got %0d, need 2", frames_pending);
    end
    base = frames_sent;
    module_transmit_data_ready = 1'b1;
    wait_frames(base + 1);
    n_vec++;
    if (frames_pending !== 5'd1) begin
      n_err++;
      $display("FAIL t3_pend1: got %0d, need 1", frames_pending);
    end
    wait_frames(base + 2);
    n_vec++;
    if (frames_pending !== 5'd0 || last_gap != 4) begin
      n_err++;
      $display("FAIL t3_gap: got pend=%0d gap=%0d, need 0/4", frames_pending, last_gap);
    end
    wait_idle();
  endtask

  task automatic test_overflow();
    write_enable = 1'b1;
    write_last   = 1'b0;
    for (int i = 0; i < 2048; i++) begin
      write_data = 8'(i);
      tick();
    end
    write_enable = 1'b0;
    n_vec++;
    if (write_ready !== 1'b0 || overflow_error !== 1'b0) begin
      n_err++;
      $display("FAIL t4_full: got rdy=%b ovf=%b, need 0/0", write_ready, overflow_error);
    end
    write_enable = 1'b1;
    tick();
    n_vec++;
    if (overflow_error !== 1'b1) begin
      n_err++;
      $display("FAIL t4_set: got %b, need 1", overflow_error);
    end
    clear_error = 1'b1;
    tick();
    n_vec++;
    if (overflow_error !== 1'b1) begin
      n_err++;
      $display("FAIL t4_set_wins: got %b, need 1", overflow_error);
    end
    write_enable = 1'b0;
    tick();
    clear_error = 1'b0;
    n_vec++;
    if (overflow_error !== 1'b0) begin
      n_err++;
      $display("FAIL t4_clear: got %b, need 0", overflow_error);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_max_frames();
    logic [4:0] p;
    module_transmit_data_ready = 1'b0;
    for (int i = 0; i < 16; i++) push_byte(8'(i + 8'h30), 1'b1);
    n_vec++;
    if (frames_pending !== 5'd16 || write_ready !== 1'b0) begin
      n_err++;
      $display("FAIL t5_limit: got pend=%0d rdy=%b, need 16/0", frames_pending, write_ready);
    end
    module_transmit_data_ready = 1'b1;
    tick();
    n_vec++;
    if (frames_pending !== 5'd15 || write_ready !== 1'b1) begin
      n_err++;
      $display("FAIL t5_release: got pend=%0d rdy=%b, need 15/1", frames_pending, write_ready);
    end
    wait_enable();
    p            = frames_pending;
    write_data   = 8'hEE;
    write_last   = 1'b1;
    write_enable = 1'b1;
    sb.push_back(9'h1EE);
    tick();
    write_enable = 1'b0;
    write_last   = 1'b0;
    n_vec++;
    if (frames_pending !== p) begin
      n_err++;
      $display("FAIL t5_simul: got %0d, need %0d", frames_pending, p);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid_frame();
    int t = 0;
    module_transmit_data_ready = 1'b1;
    for (int i = 0; i < 10; i++) push_byte(8'(i + 8'h50), i == 9);
    while (words_in_frame != 4 && t < 5000) begin
      tick();
      t++;
    end
    if (t >= 5000) begin
      n_err++;
      $display("FAIL t6_word5_timeout: got %0d words, need 4", words_in_frame);
    end
    reset = 1'b1;
    sb.delete();
    #1;
    n_vec++;
    if (module_transmit_data_enable !== 1'b0 || frames_pending !== 5'd0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL t6_reset: got en=%b pend=%0d busy=%b, need 0/0/0",
               module_transmit_data_enable, frames_pending, busy);
    end
    tick();
    reset = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (module_transmit_data_enable !== 1'b0 || frames_pending !== 5'd0) begin
      n_err++;
      $display("FAIL t6_empty: got en=%b pend=%0d, need 0/0", module_transmit_data_enable, frames_pending);
    end
    push_byte(8'h11, 1'b0);
    push_byte(8'h22, 1'b0);
    push_byte(8'h33, 1'b1);
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_ready_toggle();
    test_two_frames();
    test_overflow();
    test_max_frames();
    test_reset_mid_frame();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL final_drain: got %0d words left, need 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
